// File: rtl/fetch.sv
// Instruction fetch: issues sequential word reads to the MMU and queues returned words for decode.
// Latency: response captured on its RVALID edge, presented to decode the following cycle.
// Backpressure: STALL holds the FIFO head; requests stop once buffered + outstanding reaches DEPTH.

module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop_rdy,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];

    // Callers never push when full nor pop when empty; DEPTH is a power of 2 so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_rdy)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_vld) - CW'(pop_rdy);
        end
    end
endmodule

module fetch #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic [31:0] NEW_PC,
    input  logic        STALL,
    input  logic        MEM_WAIT,
    output logic        INST_RDEN,
    output logic [31:0] INST_RADDR,
    input  logic        INST_RVALID,
    input  logic [31:0] INST_RDATA,
    output logic        INST_VALID,
    output logic [31:0] INST_ADDR,
    output logic [31:0] INST_DATA
);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dat;
    } inst_t;

    logic [31:0]   issue_pc;
    logic [31:0]   recv_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic          req_acc;
    logic          rsp_vld;
    logic          push_vld;
    logic          pop_rdy;
    inst_t         push_dat;
    inst_t         head_dat;
    logic [31:0]   redirect_pc;

    // Credit check covers both buffered words and words still owed by the MMU.
    assign in_use      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign INST_RDEN   = !RST && !FLUSH && (in_use < (CW+1)'(DEPTH));
    assign INST_RADDR  = issue_pc;
    assign req_acc     = INST_RDEN && !MEM_WAIT;
    assign rsp_vld     = INST_RVALID && (outstanding != '0);
    assign push_vld    = rsp_vld && !FLUSH && (discard == '0);
    assign push_dat    = '{addr: recv_pc, dat: INST_RDATA};
    assign redirect_pc = NEW_PC & ~32'h3;

    assign INST_VALID  = (fifo_count != '0);
    assign pop_rdy     = INST_VALID && !STALL && !FLUSH;
    assign INST_ADDR   = INST_VALID ? head_dat.addr : '0;
    assign INST_DATA   = INST_VALID ? head_dat.dat  : '0;

    fifo #(
        .WIDTH ($bits(inst_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .clr      (FLUSH),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (pop_rdy),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            issue_pc    <= START_ADDR;
            recv_pc     <= START_ADDR;
            outstanding <= '0;
            discard     <= '0;
        end else if (FLUSH) begin
            // Every request still owed after this cycle belongs to the old stream.
            issue_pc    <= redirect_pc;
            recv_pc     <= redirect_pc;
            outstanding <= outstanding - CW'(rsp_vld);
            discard     <= outstanding - CW'(rsp_vld);
        end else begin
            if (req_acc)
                issue_pc <= issue_pc + 32'd4;
            outstanding <= outstanding + CW'(req_acc) - CW'(rsp_vld);
            if (rsp_vld) begin
                if (discard != '0)
                    discard <= discard - CW'(1);
                else
                    recv_pc <= recv_pc + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Randomised bench for fetch: an in-order MMU model with configurable latency feeds the DUT and
// every instruction taken by decode must continue the sequential stream from the last redirect.
module tb_fetch;
    localparam logic [31:0] START = 32'h0000_0000;
    localparam int          DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FLUSH = 1'b0;
    logic [31:0] NEW_PC = '0;
    logic        STALL = 1'b0;
    logic        MEM_WAIT = 1'b0;
    logic        INST_RDEN;
    logic [31:0] INST_RADDR;
    logic        INST_RVALID = 1'b0;
    logic [31:0] INST_RDATA = '0;
    logic        INST_VALID;
    logic [31:0] INST_ADDR;
    logic [31:0] INST_DATA;

    fetch #(.START_ADDR(START), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .NEW_PC(NEW_PC), .STALL(STALL),
        .MEM_WAIT(MEM_WAIT), .INST_RDEN(INST_RDEN), .INST_RADDR(INST_RADDR),
        .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA), .INST_VALID(INST_VALID),
        .INST_ADDR(INST_ADDR), .INST_DATA(INST_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    int          lat = 1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc = START;
    logic [31:0] exp_issue = START;
    int          acc_count = 0;
    int          consumed = 0;
    logic [31:0] last_cons_addr = '0;
    bit          post_rst = 0;
    bit          post_flush = 0;
    bit          hold_req = 0;
    logic [31:0] hold_addr = '0;
    logic        s_valid, s_rden, s_rvalid;
    logic [31:0] s_addr, s_raddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, sample and update the reference stream, then take the rising edge.
    task automatic step(input bit rst, input bit stall, input bit mwait, input bit flush,
                        input logic [31:0] npc);
        bit rv;
        @(negedge CLK);
        rv = !rst && (mq.size() != 0) && (mq[0].due <= cyc);
        RST = rst; STALL = stall; MEM_WAIT = mwait; FLUSH = flush; NEW_PC = npc;
        INST_RVALID = rv;
        INST_RDATA  = rv ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
        #1;
        s_valid = INST_VALID; s_addr = INST_ADDR; s_rden = INST_RDEN;
        s_raddr = INST_RADDR; s_rvalid = rv;

        if (rst) check("rden_in_reset", INST_RDEN, 0);
        if (post_rst && !rst) begin
            check("rst_valid", INST_VALID, 0);
            check("rst_raddr", INST_RADDR, START);
            check("rst_addr", INST_ADDR, 0);
            check("rst_data", INST_DATA, 0);
            if (!flush) check("first_req", INST_RDEN, 1);
        end
        if (post_flush && !rst) check("valid_after_flush", INST_VALID, 0);
        if (!rst && !INST_VALID) begin
            check("idle_addr", INST_ADDR, 0);
            check("idle_data", INST_DATA, 0);
        end
        if (flush && !rst) check("rden_in_flush", INST_RDEN, 0);
        if (hold_req && !rst && !flush) begin
            check("wait_hold_rden", INST_RDEN, 1);
            check("wait_hold_raddr", INST_RADDR, hold_addr);
        end

        if (!rst && INST_RDEN && !mwait) begin
            check("issue_addr", INST_RADDR, exp_issue);
            mq.push_back('{addr: INST_RADDR, due: cyc + lat});
            exp_issue += 32'd4;
            acc_count++;
        end
        if (!rst && !flush && INST_VALID && !stall) begin
            check("dec_addr", INST_ADDR, exp_pc);
            check("dec_data", INST_DATA, mem_word(exp_pc));
            last_cons_addr = INST_ADDR;
            exp_pc += 32'd4;
            consumed++;
        end
        if (rv) void'(mq.pop_front());
        if (!rst) check("credit_bound", (mq.size() <= DEPTH), 1);

        hold_req  = !rst && !flush && INST_RDEN && mwait;
        hold_addr = INST_RADDR;
        if (flush) begin
            exp_pc    = npc & ~32'h3;
            exp_issue = npc & ~32'h3;
        end
        if (rst) begin
            mq.delete();
            exp_pc    = START;
            exp_issue = START;
        end
        post_rst   = rst;
        post_flush = flush && !rst;
        @(posedge CLK);
        cyc++;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    task automatic expect_next_consumed(input string tag, input logic [31:0] want);
        int  c0;
        bit  got;
        c0  = consumed;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(0, 0, 0, 0, 0);
            if (consumed != c0) got = 1;
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
        else      check(tag, last_cons_addr, want);
    endtask

    initial begin
        int a0, c0;
        logic [31:0] npc;

        // Streaming at latency 1: one instruction per cycle once the pipe is primed.
        lat = 1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            if (i >= 2) check("stream_valid", s_valid, 1);
        end

        // Decode stalled: credit allows exactly DEPTH requests, head stays at START.
        do_reset();
        a0 = acc_count;
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        check("stall_req_count", acc_count - a0, DEPTH);
        check("stall_head_valid", s_valid, 1);
        check("stall_head_addr", s_addr, START);
        c0 = consumed;
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);
        check("stall_release_progress", (consumed - c0 >= 6), 1);

        // MMU wait: request held for three cycles, accepted on the fourth.
        do_reset();
        a0 = acc_count;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            check("mwait_rden", s_rden, 1);
            check("mwait_raddr", s_raddr, START);
        end
        check("mwait_no_accept", acc_count - a0, 0);
        step(0, 0, 0, 0, 0);
        check("mwait_accept", acc_count - a0, 1);

        // Flush at latency 3 with three requests in flight; target bits [1:0] dropped.
        lat = 3;
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0103);
        expect_next_consumed("flush_lat3_first", 32'h0000_0100);

        // Flush coinciding with a response and a pending pop.
        lat = 2;
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0200);
        check("coinc_valid", s_valid, 1);
        check("coinc_rvalid", s_rvalid, 1);
        expect_next_consumed("flush_coinc_first", 32'h0000_0200);

        // Reset with words both buffered and outstanding.
        lat = 3;
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_next_consumed("after_rst_first", START);

        // Random mix of stalls, waits, redirects, resets and latency changes.
        lat = 1;
        do_reset();
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) lat = $urandom_range(1, 4);
            npc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0), npc);
        end
        check("random_progress", (consumed - c0 >= 500), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
